// File: rtl/pipe_seg_ctrl_if.sv
// Stall/flush interface between the hazard unit (master) and the pipeline
// segment controller (slave). It carries the PC/instruction inputs, the per-stage
// state outputs and the debug-bus performance counters.
interface pipe_seg_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  // Hazard unit / fetch -> segment controller
  logic [31:0]          pc_next;
  logic [31:0]          inst_if;
  logic                 stall_if;
  logic                 stall_id;
  logic                 stall_ex;
  logic                 flush_if;
  logic                 flush_id;
  logic                 flush_ex;
  logic                 flush_mem;

  // Segment controller -> pipeline / debug bus
  logic [31:0]          pc_if;
  logic [31:0]          pc_id;
  logic [31:0]          pc_ex;
  logic [31:0]          pc_mem;
  logic [31:0]          pc_wb;
  logic [31:0]          inst_id;
  logic [31:0]          inst_ex;
  logic [31:0]          inst_mem;
  logic [31:0]          inst_wb;
  logic                 valid_id;
  logic                 valid_ex;
  logic                 valid_mem;
  logic                 valid_wb;
  logic [CNT_WIDTH-1:0] cnt_cycle;
  logic [CNT_WIDTH-1:0] cnt_retire;
  logic [CNT_WIDTH-1:0] cnt_stall;
  logic [CNT_WIDTH-1:0] cnt_flush;

  modport slave (
    input  pc_next, inst_if,
    input  stall_if, stall_id, stall_ex,
    input  flush_if, flush_id, flush_ex, flush_mem,
    output pc_if, pc_id, pc_ex, pc_mem, pc_wb,
    output inst_id, inst_ex, inst_mem, inst_wb,
    output valid_id, valid_ex, valid_mem, valid_wb,
    output cnt_cycle, cnt_retire, cnt_stall, cnt_flush
  );

  modport master (
    output pc_next, inst_if,
    output stall_if, stall_id, stall_ex,
    output flush_if, flush_id, flush_ex, flush_mem,
    input  pc_if, pc_id, pc_ex, pc_mem, pc_wb,
    input  inst_id, inst_ex, inst_mem, inst_wb,
    input  valid_id, valid_ex, valid_mem, valid_wb,
    input  cnt_cycle, cnt_retire, cnt_stall, cnt_flush
  );
endinterface

// File: rtl/pipe_seg_ctrl.sv
// Pipeline segment controller for the 5-stage RV32 core. Owns the PC register and
// the IF/ID, ID/EX, EX/MEM and MEM/WB segments, applies stall > flush > advance
// per segment, and keeps cycle/retire/stall/flush counters for the debug bus.
module pipe_seg_ctrl #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rstn,
  pipe_seg_ctrl_if.slave bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } seg_t;

  localparam seg_t BUBBLE = '{pc: 32'h0, inst: NOP_INST, valid: 1'b0};

  logic [31:0]          r_pc;
  seg_t                 r_ifid, r_idex, r_exmem, r_memwb;
  logic [CNT_WIDTH-1:0] r_cnt_cycle, r_cnt_retire, r_cnt_stall, r_cnt_flush;

  logic [31:0]          w_pc_nxt;
  seg_t                 w_ifid_nxt, w_idex_nxt, w_exmem_nxt;
  logic                 w_kill_id, w_kill_ex, w_kill_mem;
  logic [1:0]           w_flush_inc;

  // flush_if is part of the hazard-unit contract but the PC is only ever
  // redirected through pc_next, so the request is deliberately dropped here.
  logic                 w_unused_flush_if;
  assign w_unused_flush_if = bus.flush_if;

  // Next-state selection for every segment: stall holds, flush bubbles, else advance.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the block can
    // leave it unassigned and infer a latch.
    w_pc_nxt    = r_pc;
    w_ifid_nxt  = r_ifid;
    w_idex_nxt  = r_idex;
    w_exmem_nxt = r_exmem;

    if (!bus.stall_if) w_pc_nxt = bus.pc_next;

    if (!bus.stall_id) begin
      if (bus.flush_id) w_ifid_nxt = BUBBLE;
      else              w_ifid_nxt = '{pc: r_pc, inst: bus.inst_if, valid: 1'b1};
    end

    if (!bus.stall_ex) begin
      if (bus.flush_ex) w_idex_nxt = BUBBLE;
      else              w_idex_nxt = r_ifid;
    end

    if (bus.flush_mem) w_exmem_nxt = BUBBLE;
    else               w_exmem_nxt = r_idex;
  end

  // A flush only counts when it actually destroys a live instruction; the
  // fetch stage is always treated as holding one.
  assign w_kill_id   = bus.flush_id  && !bus.stall_id;
  assign w_kill_ex   = bus.flush_ex  && !bus.stall_ex && r_ifid.valid;
  assign w_kill_mem  = bus.flush_mem && r_idex.valid;
  assign w_flush_inc = 2'(w_kill_id) + 2'(w_kill_ex) + 2'(w_kill_mem);

  // PC register and pipeline segments.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: every register is reset asynchronously so a reset landing in the
    // middle of a stall or flush discards all in-flight state at once.
    if (!rstn) begin
      r_pc    <= PC_RESET;
      r_ifid  <= BUBBLE;
      r_idex  <= BUBBLE;
      r_exmem <= BUBBLE;
      r_memwb <= BUBBLE;
    end else begin
      // NOTE: non-blocking assignments so every segment samples its upstream
      // neighbour's pre-edge value, independent of statement order.
      r_pc    <= w_pc_nxt;
      r_ifid  <= w_ifid_nxt;
      r_idex  <= w_idex_nxt;
      r_exmem <= w_exmem_nxt;
      r_memwb <= r_exmem;
    end
  end

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt_cycle  <= '0;
      r_cnt_retire <= '0;
      r_cnt_stall  <= '0;
      r_cnt_flush  <= '0;
    end else begin
      r_cnt_cycle  <= r_cnt_cycle  + 1'b1;
      r_cnt_retire <= r_cnt_retire + CNT_WIDTH'(r_memwb.valid);
      r_cnt_stall  <= r_cnt_stall  + CNT_WIDTH'(bus.stall_if);
      r_cnt_flush  <= r_cnt_flush  + CNT_WIDTH'(w_flush_inc);
    end
  end

  assign bus.pc_if      = r_pc;
  assign bus.pc_id      = r_ifid.pc;
  assign bus.pc_ex      = r_idex.pc;
  assign bus.pc_mem     = r_exmem.pc;
  assign bus.pc_wb      = r_memwb.pc;
  assign bus.inst_id    = r_ifid.inst;
  assign bus.inst_ex    = r_idex.inst;
  assign bus.inst_mem   = r_exmem.inst;
  assign bus.inst_wb    = r_memwb.inst;
  assign bus.valid_id   = r_ifid.valid;
  assign bus.valid_ex   = r_idex.valid;
  assign bus.valid_mem  = r_exmem.valid;
  assign bus.valid_wb   = r_memwb.valid;
  assign bus.cnt_cycle  = r_cnt_cycle;
  assign bus.cnt_retire = r_cnt_retire;
  assign bus.cnt_stall  = r_cnt_stall;
  assign bus.cnt_flush  = r_cnt_flush;

endmodule

// File: tb/tb_pipe_seg_ctrl.sv
// Self-checking bench for pipe_seg_ctrl: a hand-derived vector table plus a
// scoreboard fed by a behavioural pipeline model, a narrow-counter instance for
// wrap-around, and an asynchronous reset in the middle of a load-use stall.
module tb_pipe_seg_ctrl;

  localparam logic [31:0] PC_RST = 32'h0000_3000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // Control word: {stall_if, stall_id, stall_ex, flush_if, flush_id, flush_ex, flush_mem}
  localparam logic [6:0] C_RUN  = 7'b000_0000;
  localparam logic [6:0] C_LU   = 7'b111_0001;
  localparam logic [6:0] C_BR   = 7'b000_0110;
  localparam logic [6:0] C_SFID = 7'b010_0100;
  localparam logic [6:0] C_SFEX = 7'b001_0010;
  localparam logic [6:0] C_FIF  = 7'b000_1000;
  localparam logic [6:0] C_FMEM = 7'b000_0001;
  localparam logic [6:0] C_F3   = 7'b000_0111;
  localparam logic [6:0] C_FEM  = 7'b000_0011;
  localparam logic [6:0] C_SIF  = 7'b100_0000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pipe_seg_ctrl_if #(.CNT_WIDTH(32)) bus ();
  pipe_seg_ctrl_if #(.CNT_WIDTH(4))  bus_w ();

  pipe_seg_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));
  pipe_seg_ctrl #(.CNT_WIDTH(4)) dut_w (.clk(clk), .rstn(rstn), .bus(bus_w));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
  } seg_t;

  typedef struct {
    logic [31:0] pc_if;
    seg_t        s [4];
    logic [31:0] cyc, ret, stl, fl;
  } snap_t;

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] pc_nx;   // 0 selects sequential pc+4
    logic [31:0] e_pc;
    logic [3:0]  e_val;   // {valid_id, valid_ex, valid_mem, valid_wb}
    logic [31:0] e_fl;
    logic [31:0] e_stl;
  } vec_t;

  snap_t       sb_q [$];
  logic [31:0] m_pc;
  seg_t        m_s [4];
  logic [31:0] m_cyc, m_ret, m_stl, m_fl;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          steps_since_rst = 0;
  vec_t        vt [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    m_pc = PC_RST;
    for (int i = 0; i < 4; i++) m_s[i] = '{pc: 32'h0, inst: NOP, valid: 1'b0};
    m_cyc = 0; m_ret = 0; m_stl = 0; m_fl = 0;
    sb_q.delete();
    steps_since_rst = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc_if"},  bus.pc_if, PC_RST);
    check({tag, "_pc_id"},  bus.pc_id, 32'h0);
    check({tag, "_pc_ex"},  bus.pc_ex, 32'h0);
    check({tag, "_pc_mem"}, bus.pc_mem, 32'h0);
    check({tag, "_pc_wb"},  bus.pc_wb, 32'h0);
    check({tag, "_inst_id"},  bus.inst_id, NOP);
    check({tag, "_inst_wb"},  bus.inst_wb, NOP);
    check({tag, "_valids"}, {28'h0, bus.valid_id, bus.valid_ex, bus.valid_mem, bus.valid_wb}, 32'h0);
    check({tag, "_cnt_cycle"},  bus.cnt_cycle, 32'h0);
    check({tag, "_cnt_retire"}, bus.cnt_retire, 32'h0);
    check({tag, "_cnt_stall"},  bus.cnt_stall, 32'h0);
    check({tag, "_cnt_flush"},  bus.cnt_flush, 32'h0);
    check({tag, "_w_cnt_cycle"}, {28'h0, bus_w.cnt_cycle}, 32'h0);
  endtask

  task automatic compare_snap(input snap_t e);
    check("sb_pc_if",    bus.pc_if,    e.pc_if);
    check("sb_pc_id",    bus.pc_id,    e.s[0].pc);
    check("sb_pc_ex",    bus.pc_ex,    e.s[1].pc);
    check("sb_pc_mem",   bus.pc_mem,   e.s[2].pc);
    check("sb_pc_wb",    bus.pc_wb,    e.s[3].pc);
    check("sb_inst_id",  bus.inst_id,  e.s[0].inst);
    check("sb_inst_ex",  bus.inst_ex,  e.s[1].inst);
    check("sb_inst_mem", bus.inst_mem, e.s[2].inst);
    check("sb_inst_wb",  bus.inst_wb,  e.s[3].inst);
    check("sb_valid_id",  {31'h0, bus.valid_id},  {31'h0, e.s[0].valid});
    check("sb_valid_ex",  {31'h0, bus.valid_ex},  {31'h0, e.s[1].valid});
    check("sb_valid_mem", {31'h0, bus.valid_mem}, {31'h0, e.s[2].valid});
    check("sb_valid_wb",  {31'h0, bus.valid_wb},  {31'h0, e.s[3].valid});
    check("sb_cnt_cycle",  bus.cnt_cycle,  e.cyc);
    check("sb_cnt_retire", bus.cnt_retire, e.ret);
    check("sb_cnt_stall",  bus.cnt_stall,  e.stl);
    check("sb_cnt_flush",  bus.cnt_flush,  e.fl);
  endtask

  // Drive one cycle of controls, predict the post-edge state, then compare it.
  task automatic step(input logic [6:0] ctl, input logic [31:0] pc_nx);
    logic [31:0] nxt, inst;
    logic        sif, sid, sex, fid, fex, fmem;
    logic        kid, kex, kmem;
    snap_t       e;
    nxt  = (pc_nx == 32'h0) ? m_pc + 32'd4 : pc_nx;
    inst = m_pc ^ 32'hA5A5_0000;
    {bus.stall_if, bus.stall_id, bus.stall_ex, bus.flush_if,
     bus.flush_id, bus.flush_ex, bus.flush_mem} = ctl;
    bus.pc_next = nxt;
    bus.inst_if = inst;
    {sif, sid, sex} = ctl[6:4];
    {fid, fex, fmem} = ctl[2:0];

    kid  = fid && !sid;
    kex  = fex && !sex && m_s[0].valid;
    kmem = fmem && m_s[1].valid;
    m_cyc = m_cyc + 1;
    m_ret = m_ret + 32'(m_s[3].valid);
    m_stl = m_stl + 32'(sif);
    m_fl  = m_fl + 32'(kid) + 32'(kex) + 32'(kmem);
    m_s[3] = m_s[2];
    m_s[2] = fmem ? '{pc: 32'h0, inst: NOP, valid: 1'b0} : m_s[1];
    if (!sex) m_s[1] = fex ? '{pc: 32'h0, inst: NOP, valid: 1'b0} : m_s[0];
    if (!sid) m_s[0] = fid ? '{pc: 32'h0, inst: NOP, valid: 1'b0}
                           : '{pc: m_pc, inst: inst, valid: 1'b1};
    if (!sif) m_pc = nxt;

    e.pc_if = m_pc; e.s = m_s;
    e.cyc = m_cyc; e.ret = m_ret; e.stl = m_stl; e.fl = m_fl;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    steps_since_rst++;
    if (sb_q.size() == 0) check("sb_empty", 32'h0, 32'h1);
    else compare_snap(sb_q.pop_front());
    if (steps_since_rst == 15) check("wrap_pre",  {28'h0, bus_w.cnt_cycle}, 32'hF);
    if (steps_since_rst == 16) check("wrap_zero", {28'h0, bus_w.cnt_cycle}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] all_v;
    all_v = 4'hF;
    // Free run: one new valid stage per cycle until the pipe is full.
    for (int i = 0; i < 10; i++)
      vt[i] = '{C_RUN, 32'h0, PC_RST + 32'd4 * (i + 1),
                all_v << (3 - ((i < 3) ? i : 3)), 32'd0, 32'd0};
    vt[10] = '{C_LU,   32'h0,   32'h3028, 4'b1101, 32'd1, 32'd1};  // load-use
    vt[11] = '{C_RUN,  32'h0,   32'h302C, 4'b1110, 32'd1, 32'd1};
    vt[12] = '{C_BR,   32'h3100, 32'h3100, 4'b0011, 32'd3, 32'd1}; // branch
    vt[13] = '{C_RUN,  32'h0,   32'h3104, 4'b1001, 32'd3, 32'd1};
    vt[14] = '{C_SFID, 32'h0,   32'h3108, 4'b1100, 32'd3, 32'd1};  // stall beats flush
    vt[15] = '{C_SFEX, 32'h0,   32'h310C, 4'b1110, 32'd3, 32'd1};
    vt[16] = '{C_FIF,  32'h0,   32'h3110, 4'b1111, 32'd3, 32'd1};  // flush_if ignored
    vt[17] = '{C_FMEM, 32'h0,   32'h3114, 4'b1101, 32'd4, 32'd1};
    vt[18] = '{C_F3,   32'h0,   32'h3118, 4'b0000, 32'd7, 32'd1};  // three kills at once
    vt[19] = '{C_FEM,  32'h0,   32'h311C, 4'b1000, 32'd7, 32'd1};  // bubbles over bubbles
    vt[20] = '{C_SIF,  32'h0,   32'h311C, 4'b1100, 32'd7, 32'd2};

    {bus.stall_if, bus.stall_id, bus.stall_ex, bus.flush_if,
     bus.flush_id, bus.flush_ex, bus.flush_mem} = 7'h0;
    bus.pc_next = 32'h0; bus.inst_if = 32'h0;
    {bus_w.stall_if, bus_w.stall_id, bus_w.stall_ex, bus_w.flush_if,
     bus_w.flush_id, bus_w.flush_ex, bus_w.flush_mem} = 7'h0;
    bus_w.pc_next = 32'h0; bus_w.inst_if = 32'h0;

    #12;
    check_reset("rst");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(vt[i].ctl, vt[i].pc_nx);
      check($sformatf("vec%0d_pc_if", i), bus.pc_if, vt[i].e_pc);
      check($sformatf("vec%0d_valids", i),
            {28'h0, bus.valid_id, bus.valid_ex, bus.valid_mem, bus.valid_wb},
            {28'h0, vt[i].e_val});
      check($sformatf("vec%0d_cnt_flush", i), bus.cnt_flush, vt[i].e_fl);
      check($sformatf("vec%0d_cnt_stall", i), bus.cnt_stall, vt[i].e_stl);
      if (i == 9) begin
        check("run10_cnt_retire", bus.cnt_retire, 32'd6);
        check("run10_cnt_cycle",  bus.cnt_cycle,  32'd10);
      end
    end

    // Asynchronous reset landing between edges during a load-use stall.
    {bus.stall_if, bus.stall_id, bus.stall_ex, bus.flush_if,
     bus.flush_id, bus.flush_ex, bus.flush_mem} = C_LU;
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check_reset("async_rst");
    @(posedge clk);
    #2;
    check_reset("held_rst");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

    step(C_RUN, 32'h0);
    check("refetch_pc_id",    bus.pc_id, PC_RST);
    check("refetch_valid_id", {31'h0, bus.valid_id}, 32'h1);
    for (int i = 0; i < 5; i++) step(C_RUN, 32'h0);
    check("refetch_pc_if", bus.pc_if, PC_RST + 32'd24);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
